template_scan_gen: RTL and testbench

Synthesizable raster-scan address sequencer for the template-matching datapath. It runs on the system clock and enumerates every candidate window position of the template over the image. Within each window it issues one image-memory address and one template-memory address per accepted beat. It sits between the image/template memories and the downstream difference accumulator, with a valid/ready stream on its output side.

---
 rtl/template_scan_gen_if.sv | 27 ++
 rtl/template_scan_gen.sv | 170 +++++++++++++++++
 tb/tb_template_scan_gen.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/template_scan_gen_if.sv
// Output beat stream of template_scan_gen: addresses, window origin and
// window markers under a valid/ready handshake.
interface template_scan_gen_if #(
  parameter int ADDR_W  = 12,
  parameter int TADDR_W = 6,
  parameter int XW      = 6,
  parameter int YW      = 6
);
  logic               pix_valid;
  logic               pix_ready;
  logic [ADDR_W-1:0]  img_addr;
  logic [TADDR_W-1:0] tpl_addr;
  logic [XW-1:0]      win_x;
  logic [YW-1:0]      win_y;
  logic               win_first;
  logic               win_last;

  modport master (
    output pix_valid, img_addr, tpl_addr, win_x, win_y, win_first, win_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, img_addr, tpl_addr, win_x, win_y, win_first, win_last,
    output pix_ready
  );
endinterface

// File: rtl/template_scan_gen.sv
// Raster-scan address sequencer enumerating every template window over the image.
// Optional macro SCAN_ABORT_EN adds an abort input that cancels a scan in progress.
module template_scan_gen #(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int TPL_W   = 8,
  parameter int TPL_H   = 8,
  parameter int ADDR_W  = 12,
  parameter int TADDR_W = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
`ifdef SCAN_ABORT_EN
  input  logic abort,
`endif
  template_scan_gen_if.master pix,
  output logic busy,
  output logic done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int UW = (TPL_W > 1) ? $clog2(TPL_W) : 1;
  localparam int VW = (TPL_H > 1) ? $clog2(TPL_H) : 1;

  localparam logic [UW-1:0] U_MAX  = UW'(TPL_W - 1);
  localparam logic [VW-1:0] V_MAX  = VW'(TPL_H - 1);
  localparam logic [XW-1:0] WX_MAX = XW'(IMG_W - TPL_W);
  localparam logic [YW-1:0] WY_MAX = YW'(IMG_H - TPL_H);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [UW-1:0]      u_q, u_d;
  logic [VW-1:0]      v_q, v_d;
  logic [XW-1:0]      wx_q, wx_d;
  logic [YW-1:0]      wy_q, wy_d;

  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ADDR_W-1:0]  img_addr_q, img_addr_d;
  logic [TADDR_W-1:0] tpl_addr_q, tpl_addr_d;
  logic               first_q, first_d;
  logic               last_q, last_d;

  logic               final_beat;
  logic               scan_d;
  logic [31:0]        img_full;
  logic [31:0]        tpl_full;

  assign final_beat = (u_q == U_MAX) && (v_q == V_MAX) &&
                      (wx_q == WX_MAX) && (wy_q == WY_MAX);

  always_comb begin
    state_d    = state_q;
    u_d        = u_q;
    v_d        = v_q;
    wx_d       = wx_q;
    wy_d       = wy_q;

    unique case (state_q)
      S_IDLE: begin
        u_d  = '0;
        v_d  = '0;
        wx_d = '0;
        wy_d = '0;
        if (start) state_d = S_SCAN;
      end
      S_SCAN: begin
`ifdef SCAN_ABORT_EN
        if (abort) begin
          state_d = S_IDLE;
          u_d     = '0;
          v_d     = '0;
          wx_d    = '0;
          wy_d    = '0;
        end else
`endif
        if (pix.pix_ready) begin
          if (final_beat) begin
            state_d = S_DONE;
            u_d     = '0;
            v_d     = '0;
            wx_d    = '0;
            wy_d    = '0;
          end else if (u_q != U_MAX) begin
            u_d = u_q + UW'(1);
          end else begin
            u_d = '0;
            if (v_q != V_MAX) begin
              v_d = v_q + VW'(1);
            end else begin
              v_d = '0;
              if (wx_q != WX_MAX) begin
                wx_d = wx_q + XW'(1);
              end else begin
                wx_d = '0;
                wy_d = wy_q + YW'(1);
              end
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are precomputed from the next counter values so that every
    // output is a flop and holds naturally while pix_ready is low.
    scan_d   = (state_d == S_SCAN);
    img_full = (32'(wy_d) + 32'(v_d)) * 32'(IMG_W) + 32'(wx_d) + 32'(u_d);
    tpl_full = 32'(v_d) * 32'(TPL_W) + 32'(u_d);

    valid_d    = scan_d;
    busy_d     = scan_d;
    done_d     = (state_q == S_SCAN) && (state_d == S_DONE);
    img_addr_d = scan_d ? img_full[ADDR_W-1:0]  : '0;
    tpl_addr_d = scan_d ? tpl_full[TADDR_W-1:0] : '0;
    first_d    = scan_d && (u_d == '0) && (v_d == '0);
    last_d     = scan_d && (u_d == U_MAX) && (v_d == V_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      u_q        <= '0;
      v_q        <= '0;
      wx_q       <= '0;
      wy_q       <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      img_addr_q <= '0;
      tpl_addr_q <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      u_q        <= u_d;
      v_q        <= v_d;
      wx_q       <= wx_d;
      wy_q       <= wy_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      img_addr_q <= img_addr_d;
      tpl_addr_q <= tpl_addr_d;
      first_q    <= first_d;
      last_q     <= last_d;
    end
  end

  assign pix.pix_valid = valid_q;
  assign pix.img_addr  = img_addr_q;
  assign pix.tpl_addr  = tpl_addr_q;
  assign pix.win_x     = wx_q;
  assign pix.win_y     = wy_q;
  assign pix.win_first = first_q;
  assign pix.win_last  = last_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_template_scan_gen.sv
// Directed bench for template_scan_gen with a 4x3 image and 2x2 template.
module tb_template_scan_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic abort;
  logic busy;
  logic done;

  int tests = 0;
  int fails = 0;

  int exp_img [24] = '{0, 1, 4, 5,   1, 2, 5, 6,   2, 3, 6, 7,
                       4, 5, 8, 9,   5, 6, 9, 10,  6, 7, 10, 11};

  always #5 clk = ~clk;

  template_scan_gen_if #(.ADDR_W(4), .TADDR_W(2), .XW(2), .YW(2)) pif ();

  template_scan_gen #(
    .IMG_W(4), .IMG_H(3), .TPL_W(2), .TPL_H(2), .ADDR_W(4), .TADDR_W(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SCAN_ABORT_EN
    .abort (abort),
`endif
    .pix   (pif.master),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end

  task automatic start_scan();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs accepted beats 0..stop-1 and checks each presented beat;
  // returns at #1 after the edge that accepted beat stop-1.
  task automatic drive_until(input int stop, input int mode, output int dones);
    int  idx = 0;
    int  cyc = 0;
    bit  rdy;
    logic [14:0] got, exp;
    dones = 0;
    while (idx < stop && cyc < 400) begin
      rdy = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
      pif.pix_ready = rdy;
      start = (mode == 2) && (cyc == 3 || cyc == 7);
      got = {pif.pix_valid, busy, done, pif.img_addr, pif.tpl_addr,
             pif.win_x, pif.win_y, pif.win_first, pif.win_last};
      exp = {1'b1, 1'b1, 1'b0, 4'(exp_img[idx]), 2'(idx % 4),
             2'((idx / 4) % 3), 2'(idx / 12), idx % 4 == 0, idx % 4 == 3};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL beat%0d cyc%0d got v/b/d=%b%b%b img=%0d tpl=%0d x=%0d y=%0d f=%b l=%b required img=%0d tpl=%0d x=%0d y=%0d f=%b l=%b",
                 idx, cyc, got[14], got[13], got[12], got[11:8], got[7:6], got[5:4],
                 got[3:2], got[1], got[0], exp[11:8], exp[7:6], exp[5:4], exp[3:2], exp[1], exp[0]);
      end
      if (done) dones++;
      @(posedge clk); #1;
      if (rdy) idx++;
      cyc++;
    end
    start = 1'b0;
    tests++;
    if (idx < stop) begin
      fails++;
      $display("FAIL beat_budget got=%0d beats required=%0d", idx, stop);
    end
  endtask

  task automatic check_idle(input string name);
    tests++;
    if ({pif.pix_valid, busy, done, pif.img_addr, pif.tpl_addr, pif.win_x,
         pif.win_y, pif.win_first, pif.win_last} !== '0) begin
      fails++;
      $display("FAIL %s got v=%b b=%b d=%b img=%0d tpl=%0d x=%0d y=%0d f=%b l=%b required all zero",
               name, pif.pix_valid, busy, done, pif.img_addr, pif.tpl_addr,
               pif.win_x, pif.win_y, pif.win_first, pif.win_last);
    end
  endtask

  task automatic run_scan(input int mode);
    int dones;
    start_scan();
    drive_until(24, mode, dones);
    tests++;
    if (dones != 0) begin
      fails++;
      $display("FAIL early_done got=%0d required=0", dones);
    end
    tests++;
    if ({pif.pix_valid, busy, done} !== 3'b001) begin
      fails++;
      $display("FAIL done_pulse got v/b/d=%b%b%b required 001", pif.pix_valid, busy, done);
    end
    if (mode == 2) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_idle("after_done");
    repeat (3) @(posedge clk);
    #1;
    check_idle("stays_idle");
  endtask

  task automatic test_reset();
    start = 1'b0;
    abort = 1'b0;
    pif.pix_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #6;
    check_idle("reset_assert");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_release");
  endtask

  task automatic test_full_scan();
    run_scan(0);
  endtask

  task automatic test_backpressure();
    run_scan(1);
  endtask

  task automatic test_start_ignored();
    run_scan(2);
  endtask

  task automatic test_back_to_back();
    int dones;
    start_scan();
    drive_until(24, 0, dones);
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL b2b_done got=%b required=1", done);
    end
    @(posedge clk); #1;
    start_scan();
    drive_until(24, 0, dones);
    tests++;
    if ({pif.pix_valid, busy, done} !== 3'b001 || dones != 0) begin
      fails++;
      $display("FAIL b2b_second_done got v/b/d=%b%b%b early=%0d required 001 early=0",
               pif.pix_valid, busy, done, dones);
    end
    @(posedge clk); #1;
    check_idle("b2b_idle");
  endtask

  task automatic test_reset_mid_scan();
    int dones;
    int seen = 0;
    start_scan();
    drive_until(10, 0, dones);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || pif.pix_valid) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL reset_no_done got=%0d active cycles required=0", seen);
    end
    start_scan();
    drive_until(24, 0, dones);
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL reset_restart_done got=%b required=1", done);
    end
    @(posedge clk); #1;
  endtask

`ifdef SCAN_ABORT_EN
  task automatic test_abort();
    int dones;
    start_scan();
    drive_until(4, 0, dones);
    abort = 1'b1;
    pif.pix_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_idle("abort_idle");
    @(posedge clk); #1;
    check_idle("abort_no_done");
    start_scan();
    drive_until(24, 0, dones);
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL abort_restart_done got=%b required=1", done);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_full_scan();
    test_backpressure();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_scan();
`ifdef SCAN_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
